// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle controller and the datapath.
interface mc_ctrl_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zero;
  logic               overflow;
  logic               positive;
  logic               signed_less;
  logic [1:0]         alu_ctl;
  logic               ext_op;
  logic [2:0]         reg_src;
  logic [1:0]         npc_sel;
  logic               mem_write;
  logic               mem_op;
  logic               reg_write;
  logic               alu_src;
  logic [1:0]         reg_dst;
  logic               rgs_ins_write;
  logic               pc_write;
  logic               instr_done;
  logic               illegal;
  logic [STATE_W-1:0] state;

  // Controller side: consumes IR fields and ALU flags, drives all controls.
  modport master (
    input  opcode, funct, zero, overflow, positive, signed_less,
    output alu_ctl, ext_op, reg_src, npc_sel, mem_write, mem_op, reg_write,
           alu_src, reg_dst, rgs_ins_write, pc_write, instr_done, illegal, state
  );

  // Datapath side.
  modport slave (
    output opcode, funct, zero, overflow, positive, signed_less,
    input  alu_ctl, ext_op, reg_src, npc_sel, mem_write, mem_op, reg_write,
           alu_src, reg_dst, rgs_ins_write, pc_write, instr_done, illegal, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: one instruction in flight, 3-5 cycles each.
module mc_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input logic        clk,
  input logic        rst,
  mc_ctrl_if.master  bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
    MEM_RD, MEM_WR, MEM_WB, BRANCH, JUMP, JAL, JR
  } state_t;

  typedef enum logic [2:0] {
    K_NONE, K_ADDU, K_SUBU, K_SLT, K_ORI, K_ADDI, K_LW, K_SW
  } kind_t;

  state_t state_q;
  state_t dec_state;
  kind_t  kind_q;
  kind_t  dec_kind;
  logic   dec_illegal;
  logic   slt_f;
  logic   ovf_f;
  logic   unused_positive;

  assign unused_positive = bus.positive;
  assign bus.state       = state_q;

  // Opcode/funct decode; only consumed while in DECODE.
  always_comb begin
    dec_state   = FETCH;
    dec_kind    = K_NONE;
    dec_illegal = 1'b0;
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b100001: begin dec_state = EXEC_R; dec_kind = K_ADDU; end
          6'b100011: begin dec_state = EXEC_R; dec_kind = K_SUBU; end
          6'b101010: begin dec_state = EXEC_R; dec_kind = K_SLT;  end
          6'b001000: dec_state = JR;
          default:   dec_illegal = 1'b1;
        endcase
      end
      6'b001101: begin dec_state = EXEC_I;   dec_kind = K_ORI;  end
      6'b001000: begin dec_state = EXEC_I;   dec_kind = K_ADDI; end
      6'b100011: begin dec_state = MEM_ADDR; dec_kind = K_LW;   end
      6'b101011: begin dec_state = MEM_ADDR; dec_kind = K_SW;   end
      6'b000100: dec_state = BRANCH;
      6'b000010: dec_state = JUMP;
      6'b000011: dec_state = JAL;
      default:   dec_illegal = 1'b1;
    endcase
  end

  // State register plus the instruction class and ALU flag latches.
  // The class is captured in DECODE so later states never look at the IR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      kind_q  <= K_NONE;
      slt_f   <= 1'b0;
      ovf_f   <= 1'b0;
    end else begin
      case (state_q)
        FETCH:    state_q <= DECODE;
        DECODE: begin
          state_q <= dec_state;
          kind_q  <= dec_kind;
        end
        EXEC_R: begin
          state_q <= WB_R;
          slt_f   <= bus.signed_less;
        end
        EXEC_I: begin
          state_q <= WB_I;
          ovf_f   <= (kind_q == K_ADDI) && bus.overflow;
        end
        MEM_ADDR: state_q <= (kind_q == K_SW) ? MEM_WR : MEM_RD;
        MEM_RD:   state_q <= MEM_WB;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Output decode from state; everything is held at 0 while in reset.
  always_comb begin
    bus.alu_ctl       = 2'd0;
    bus.ext_op        = 1'b0;
    bus.reg_src       = 3'd0;
    bus.npc_sel       = 2'd0;
    bus.mem_write     = 1'b0;
    bus.mem_op        = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src       = 1'b0;
    bus.reg_dst       = 2'd0;
    bus.rgs_ins_write = 1'b0;
    bus.pc_write      = 1'b0;
    bus.instr_done    = 1'b0;
    bus.illegal       = 1'b0;
    if (rst) begin
      case (state_q)
        FETCH: begin
          bus.rgs_ins_write = 1'b1;
          bus.pc_write      = 1'b1;
        end
        DECODE: begin
          bus.illegal    = dec_illegal;
          bus.instr_done = dec_illegal;
        end
        EXEC_R: bus.alu_ctl = (kind_q == K_ADDU) ? 2'd0 : 2'd1;
        WB_R: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          if (kind_q == K_SLT) bus.reg_src = slt_f ? 3'd3 : 3'd2;
        end
        EXEC_I: begin
          bus.alu_src = 1'b1;
          if (kind_q == K_ORI) begin
            bus.alu_ctl = 2'd2;
          end else begin
            bus.ext_op  = 1'b1;
          end
        end
        WB_I: begin
          bus.reg_write  = 1'b1;
          bus.instr_done = 1'b1;
          bus.reg_dst    = ovf_f ? 2'd2 : 2'd1;
          bus.reg_src    = ovf_f ? 3'd3 : 3'd0;
        end
        MEM_ADDR: begin
          bus.alu_src = 1'b1;
          bus.ext_op  = 1'b1;
        end
        MEM_WR: begin
          bus.mem_write  = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'd1;
          bus.reg_src    = 3'd1;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.alu_ctl    = 2'd1;
          bus.ext_op     = 1'b1;
          bus.npc_sel    = 2'd1;
          bus.pc_write   = bus.zero;
          bus.instr_done = 1'b1;
        end
        JUMP: begin
          bus.npc_sel    = 2'd2;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
        end
        JAL: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'd3;
          bus.reg_src    = 3'd4;
          bus.npc_sel    = 2'd2;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
        end
        JR: begin
          bus.npc_sel    = 2'd3;
          bus.pc_write   = 1'b1;
          bus.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed instruction sequences push the
// expected per-cycle control vector; a negedge monitor pops and compares.
module tb_mc_ctrl;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
    S_WB_R = 4'd3, S_EXEC_I = 4'd4, S_WB_I = 4'd5, S_MEM_ADDR = 4'd6,
    S_MEM_RD = 4'd7, S_MEM_WR = 4'd8, S_MEM_WB = 4'd9, S_BRANCH = 4'd10,
    S_JUMP = 4'd11, S_JAL = 4'd12, S_JR = 4'd13;
  localparam logic [5:0] JUNK = 6'h3f;

  typedef struct packed {
    logic [1:0] alu_ctl;
    logic       ext_op;
    logic [2:0] reg_src;
    logic [1:0] npc_sel;
    logic       mem_write;
    logic       mem_op;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       rgs_ins_write;
    logic       pc_write;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t  exp_q[$];
  string name_q[$];

  mc_ctrl_if #(.STATE_W(4)) bus ();
  mc_ctrl #(.STATE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic vec_t st(input logic [3:0] s);
    vec_t v;
    v = '0;
    v.state = s;
    return v;
  endfunction

  task automatic step(input logic [5:0] opc, input logic [5:0] fn,
                      input logic z, input logic ov, input logic sl,
                      input logic r, input vec_t e, input string nm);
    @(posedge clk);
    #1;
    bus.opcode = opc; bus.funct = fn; bus.zero = z;
    bus.overflow = ov; bus.signed_less = sl; rst = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch_dec(input logic [5:0] opc, input logic [5:0] fn,
                           input string nm);
    vec_t e;
    e = st(S_FETCH); e.rgs_ins_write = 1'b1; e.pc_write = 1'b1;
    step(JUNK, JUNK, 1'b1, 1'b1, 1'b1, 1'b1, e, {nm, "_fetch"});
    e = st(S_DECODE);
    step(opc, fn, 1'b0, 1'b0, 1'b0, 1'b1, e, {nm, "_decode"});
  endtask

  task automatic r_op(input logic [5:0] fn, input logic sl,
                      input logic [1:0] x_alu, input logic [2:0] x_src,
                      input string nm);
    vec_t e;
    fetch_dec(6'b000000, fn, nm);
    e = st(S_EXEC_R); e.alu_ctl = x_alu;
    step(JUNK, JUNK, 1'b0, 1'b0, sl, 1'b1, e, {nm, "_exec"});
    e = st(S_WB_R); e.reg_write = 1'b1; e.reg_src = x_src; e.instr_done = 1'b1;
    step(JUNK, JUNK, 1'b0, 1'b0, ~sl, 1'b1, e, {nm, "_wb"});
  endtask

  task automatic i_op(input logic [5:0] opc, input logic ov,
                      input logic x_ext, input logic [1:0] x_alu,
                      input logic [1:0] x_dst, input logic [2:0] x_src,
                      input string nm);
    vec_t e;
    fetch_dec(opc, 6'b000000, nm);
    e = st(S_EXEC_I); e.alu_src = 1'b1; e.ext_op = x_ext; e.alu_ctl = x_alu;
    step(JUNK, JUNK, 1'b0, ov, 1'b0, 1'b1, e, {nm, "_exec"});
    e = st(S_WB_I); e.reg_write = 1'b1; e.instr_done = 1'b1;
    e.reg_dst = x_dst; e.reg_src = x_src;
    step(JUNK, JUNK, 1'b0, ~ov, 1'b0, 1'b1, e, {nm, "_wb"});
  endtask

  task automatic mem_addr(input logic [5:0] opc, input string nm);
    vec_t e;
    fetch_dec(opc, 6'b000000, nm);
    e = st(S_MEM_ADDR); e.alu_src = 1'b1; e.ext_op = 1'b1;
    step(JUNK, JUNK, 1'b0, 1'b0, 1'b0, 1'b1, e, {nm, "_addr"});
  endtask

  task automatic last(input logic [5:0] opc, input logic [5:0] fn,
                      input logic z, input vec_t e, input string nm);
    fetch_dec(opc, fn, nm);
    step(JUNK, JUNK, z, 1'b0, 1'b0, 1'b1, e, {nm, "_exec"});
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t act, e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = '{bus.alu_ctl, bus.ext_op, bus.reg_src, bus.npc_sel, bus.mem_write,
              bus.mem_op, bus.reg_write, bus.alu_src, bus.reg_dst,
              bus.rgs_ins_write, bus.pc_write, bus.instr_done, bus.illegal,
              bus.state};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  initial begin
    vec_t e;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
    bus.overflow = 1'b0; bus.positive = 1'b0; bus.signed_less = 1'b0;

    // Power-up reset: FETCH, everything 0.
    step(JUNK, JUNK, 1'b1, 1'b1, 1'b1, 1'b0, st(S_FETCH), "reset0");
    step(JUNK, JUNK, 1'b1, 1'b1, 1'b1, 1'b0, st(S_FETCH), "reset1");

    r_op(6'b100001, 1'b1, 2'd0, 3'd0, "addu");
    r_op(6'b100011, 1'b1, 2'd1, 3'd0, "subu");
    r_op(6'b101010, 1'b1, 2'd1, 3'd3, "slt_lt");
    r_op(6'b101010, 1'b0, 2'd1, 3'd2, "slt_ge");
    i_op(6'b001000, 1'b1, 1'b1, 2'd0, 2'd2, 3'd3, "addi_ovf");
    i_op(6'b001000, 1'b0, 1'b1, 2'd0, 2'd1, 3'd0, "addi");
    i_op(6'b001101, 1'b1, 1'b0, 2'd2, 2'd1, 3'd0, "ori");

    mem_addr(6'b100011, "lw");
    step(JUNK, JUNK, 1'b0, 1'b0, 1'b0, 1'b1, st(S_MEM_RD), "lw_rd");
    e = st(S_MEM_WB); e.reg_write = 1'b1; e.reg_dst = 2'd1; e.reg_src = 3'd1;
    e.instr_done = 1'b1;
    step(JUNK, JUNK, 1'b0, 1'b0, 1'b0, 1'b1, e, "lw_wb");

    mem_addr(6'b101011, "sw");
    e = st(S_MEM_WR); e.mem_write = 1'b1; e.instr_done = 1'b1;
    step(JUNK, JUNK, 1'b0, 1'b0, 1'b0, 1'b1, e, "sw_wr");

    e = st(S_BRANCH); e.alu_ctl = 2'd1; e.ext_op = 1'b1; e.npc_sel = 2'd1;
    e.instr_done = 1'b1; e.pc_write = 1'b1;
    last(6'b000100, 6'b000000, 1'b1, e, "beq_taken");
    e.pc_write = 1'b0;
    last(6'b000100, 6'b000000, 1'b0, e, "beq_not");

    e = st(S_JUMP); e.npc_sel = 2'd2; e.pc_write = 1'b1; e.instr_done = 1'b1;
    last(6'b000010, 6'b000000, 1'b0, e, "j");
    e = st(S_JAL); e.reg_write = 1'b1; e.reg_dst = 2'd3; e.reg_src = 3'd4;
    e.npc_sel = 2'd2; e.pc_write = 1'b1; e.instr_done = 1'b1;
    last(6'b000011, 6'b000000, 1'b0, e, "jal");
    e = st(S_JR); e.npc_sel = 2'd3; e.pc_write = 1'b1; e.instr_done = 1'b1;
    last(6'b000000, 6'b001000, 1'b0, e, "jr");

    // Illegal opcode and illegal R-type funct: flagged in DECODE, then FETCH.
    e = st(S_FETCH); e.rgs_ins_write = 1'b1; e.pc_write = 1'b1;
    step(JUNK, JUNK, 1'b0, 1'b0, 1'b0, 1'b1, e, "ill_fetch");
    e = st(S_DECODE); e.illegal = 1'b1; e.instr_done = 1'b1;
    step(6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, e, "ill_op_decode");
    e = st(S_FETCH); e.rgs_ins_write = 1'b1; e.pc_write = 1'b1;
    step(JUNK, JUNK, 1'b0, 1'b0, 1'b0, 1'b1, e, "ill_op_next");
    e = st(S_DECODE); e.illegal = 1'b1; e.instr_done = 1'b1;
    step(6'b000000, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b1, e, "ill_fn_decode");

    // Reset asserted while in MEM_WR: no strobe, then held in FETCH.
    mem_addr(6'b101011, "swrst");
    step(JUNK, JUNK, 1'b1, 1'b1, 1'b1, 1'b0, st(S_MEM_WR), "swrst_wr");
    step(JUNK, JUNK, 1'b1, 1'b1, 1'b1, 1'b0, st(S_FETCH), "swrst_hold1");
    step(JUNK, JUNK, 1'b1, 1'b1, 1'b1, 1'b0, st(S_FETCH), "swrst_hold2");
    r_op(6'b100001, 1'b0, 2'd0, 3'd0, "addu_post");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
